// File: rtl/dram_sipo_deser.sv
// Serial-in parallel-out deserializer: LSB-first frames framed by start, valid/ready output with sticky errors.
// Optional even-parity bit after the word when DRAM_SIPO_PARITY_EN is defined.
module dram_sipo_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             data_in,
  input  logic             clr_err,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH) + 1;

`ifdef DRAM_SIPO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic             word_done;
  logic [WIDTH-1:0] done_word;
  logic             last_bit;

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // start wins in every state: a restart silently abandons any partial frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = SHIFT;
      SHIFT: begin
        if (start) state_d = SHIFT;
`ifdef DRAM_SIPO_PARITY_EN
        else if (last_bit) state_d = PAR;
`else
        else if (last_bit) state_d = IDLE;
`endif
      end
`ifdef DRAM_SIPO_PARITY_EN
      PAR:   state_d = start ? SHIFT : IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_comb begin
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    if (start) begin
      shift_d    = '0;
      shift_d[0] = data_in;
      cnt_d      = CW'(1);
    end else if (state_q == SHIFT) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (cnt_q == CW'(i)) shift_d[i] = data_in;
      end
      cnt_d = cnt_q + CW'(1);
      if (last_bit) begin
        cnt_d = '0;
`ifndef DRAM_SIPO_PARITY_EN
        word_done = 1'b1;
`endif
      end
`ifdef DRAM_SIPO_PARITY_EN
    end else if (state_q == PAR) begin
      cnt_d     = '0;
      word_done = 1'b1;
`endif
    end
  end

`ifdef DRAM_SIPO_PARITY_EN
  logic par_bad;
  logic parity_err_q, parity_err_d;

  assign done_word = shift_q;
  assign par_bad   = word_done && ((^shift_q) ^ data_in);

  always_comb begin
    parity_err_d = parity_err_q;
    if (par_bad)      parity_err_d = 1'b1;
    else if (clr_err) parity_err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  assign done_word  = shift_d;
  assign parity_err = 1'b0;
`endif

  // A finished word is only dropped when the holding register is full and not draining
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (word_done && (!out_valid_q || out_ready)) begin
      out_data_d  = done_word;
      out_valid_d = 1'b1;
    end
    if (word_done && out_valid_q && !out_ready) overrun_d = 1'b1;
    else if (clr_err)                           overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_dram_sipo_deser.sv
// Directed bench for dram_sipo_deser (WIDTH=8); parity steps run when DRAM_SIPO_PARITY_EN is defined.
module tb_dram_sipo_deser;

  logic       clk = 1'b0;
  logic       rst, start, data_in, clr_err, out_ready;
  logic [7:0] out_data;
  logic       out_valid, busy, overrun, parity_err;

  int errors = 0;
  int checks = 0;

  dram_sipo_deser #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .clr_err(clr_err),
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid), .busy(busy),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic s, input logic d);
    start   = s;
    data_in = d;
    step();
    start   = 1'b0;
    data_in = 1'b0;
  endtask

  // rdy_last raises out_ready only in the final cycle of the frame; par_flip corrupts the parity bit
  task automatic send_frame(input logic [7:0] w, input logic rdy_last, input logic par_flip);
    int n;
    n = 8;
`ifdef DRAM_SIPO_PARITY_EN
    n = 9;
`endif
    for (int i = 0; i < n; i++) begin
      start   = (i == 0);
      data_in = (i < 8) ? w[i[2:0]] : ((^w) ^ par_flip);
      if (rdy_last && i == n - 1) out_ready = 1'b1;
      step();
    end
    start   = 1'b0;
    data_in = 1'b0;
    if (rdy_last) out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data_in = 1'b0; clr_err = 1'b0; out_ready = 1'b0;
    step(); step();
    check("rst_data",    32'(out_data),   32'h0);
    check("rst_valid",   32'(out_valid),  32'h0);
    check("rst_busy",    32'(busy),       32'h0);
    check("rst_overrun", 32'(overrun),    32'h0);
    check("rst_parity",  32'(parity_err), 32'h0);
    rst = 1'b0;
    step();

    // basic frame with ready held high
    out_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b0);
    check("a5_valid", 32'(out_valid), 32'h1);
    check("a5_data",  32'(out_data),  32'hA5);
    check("a5_busy",  32'(busy),      32'h0);
    step();
    check("a5_consumed", 32'(out_valid), 32'h0);

    // back-to-back frames with a stalled consumer
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0);
    check("3c_valid",   32'(out_valid), 32'h1);
    check("3c_data",    32'(out_data),  32'h3C);
    check("3c_overrun", 32'(overrun),   32'h0);
    send_frame(8'h81, 1'b0, 1'b0);
    check("81_held",    32'(out_data),  32'h3C);
    check("81_overrun", 32'(overrun),   32'h1);
    check("81_valid",   32'(out_valid), 32'h1);
    step();
    check("overrun_sticky", 32'(overrun), 32'h1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("overrun_clr", 32'(overrun), 32'h0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("drain_3c", 32'(out_valid), 32'h0);

    // consume the pending word in the same cycle the next one completes
    send_frame(8'h22, 1'b0, 1'b0);
    check("22_data", 32'(out_data), 32'h22);
    send_frame(8'h11, 1'b1, 1'b0);
    check("11_data",    32'(out_data),  32'h11);
    check("11_valid",   32'(out_valid), 32'h1);
    check("11_overrun", 32'(overrun),   32'h0);
    out_ready = 1'b1;
    step();
    check("drain_11", 32'(out_valid), 32'h0);

    // restart at bit 4
    send_bit(1'b1, 1'b1);
    check("mid_busy", 32'(busy), 32'h1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    check("mid_novalid", 32'(out_valid), 32'h0);
    send_frame(8'hF0, 1'b0, 1'b0);
    check("f0_valid",   32'(out_valid), 32'h1);
    check("f0_data",    32'(out_data),  32'hF0);
    check("f0_overrun", 32'(overrun),   32'h0);
    check("f0_parity",  32'(parity_err), 32'h0);
    step();
    check("f0_single", 32'(out_valid), 32'h0);

    // asynchronous reset at bit 3
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    check("pre_rst_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("arst_data",  32'(out_data),  32'h0);
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_busy",  32'(busy),      32'h0);
    check("arst_ovr",   32'(overrun),   32'h0);
    step();
    rst = 1'b0;
    step();
    send_frame(8'h5A, 1'b0, 1'b0);
    check("5a_valid", 32'(out_valid), 32'h1);
    check("5a_data",  32'(out_data),  32'h5A);
    step();

`ifdef DRAM_SIPO_PARITY_EN
    // 0x07 has odd weight: parity bit 0 is wrong, 1 is right
    send_frame(8'h07, 1'b0, 1'b1);
    check("p0_valid", 32'(out_valid),  32'h1);
    check("p0_data",  32'(out_data),   32'h07);
    check("p0_err",   32'(parity_err), 32'h1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("p_clr", 32'(parity_err), 32'h0);
    send_frame(8'h07, 1'b0, 1'b0);
    check("p1_data", 32'(out_data),   32'h07);
    check("p1_err",  32'(parity_err), 32'h0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dram_sipo_deser.md
DRAM_SIPO_DESER -- requirements
Module: dram_sipo_deser

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the deserialized word width in bits; legal range 2..32.
REQ-002 The module SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The module SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The module SHALL have port start  input  1  frame strobe, high in the cycle data_in carries bit 0.
REQ-005 The module SHALL have port data_in  input  1  serial bit stream, LSB first, one bit per clk.
REQ-006 The module SHALL have port clr_err  input  1  synchronous clear of sticky error flags.
REQ-007 The module SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-008 The module SHALL have port out_data  output  WIDTH  assembled parallel word.
REQ-009 The module SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-010 The module SHALL have port busy  output  1  frame capture in progress.
REQ-011 The module SHALL have port overrun  output  1  sticky, a completed word was dropped.
REQ-012 The module SHALL have port parity_err  output  1  sticky, parity mismatch (see Configuration).

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, PAR; the reset state is IDLE.
REQ-014 In IDLE, start=1 SHALL sample data_in into shift bit 0, set the bit counter to 1, and enter SHIFT.
REQ-015 In SHIFT, each cycle SHALL sample data_in into bit position counter and increment counter; no gaps are allowed.
REQ-016 Sampling bit WIDTH-1 SHALL complete the word: enter PAR if parity is enabled, otherwise return to IDLE.
REQ-017 start=1 in SHIFT or PAR SHALL abort the current frame without flagging it, and restart capture with that cycle's data_in as bit 0.
REQ-018 On completion, if out_valid=0 or out_ready=1 in the same cycle, the word SHALL load into out_data with out_valid=1 on the next cycle (latency 1 clk after the last data bit).
REQ-019 On completion with out_valid=1 and out_ready=0, the word SHALL be dropped, out_data SHALL be held, and overrun SHALL set.
REQ-020 The handshake SHALL occur when out_valid and out_ready are both high; out_valid SHALL clear the next cycle unless a new word loads in the same cycle.
REQ-021 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 busy SHALL be 1 in SHIFT and PAR, and 0 in IDLE.
REQ-023 clr_err=1 SHALL clear overrun and parity_err; a same-cycle set event SHALL take priority over the clear.
REQ-024 The bit counter SHALL be $clog2(WIDTH)+1 bits wide and never wrap within a frame.

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE, counter=0, shift register=0, out_data=0, out_valid=0, busy=0, overrun=0, parity_err=0.
REQ-026 Reset mid-frame SHALL discard the partial word; the first start after rst deasserts SHALL begin a clean frame.

Configuration
REQ-027 Macro DRAM_SIPO_PARITY_EN defined: after bit WIDTH-1, PAR SHALL sample one even-parity bit; the word SHALL be delivered regardless, and parity_err SHALL set if XOR(word, parity bit) is not 0. The frame is WIDTH+1 cycles and delivery latency is 1 clk after the parity bit.
REQ-028 Macro DRAM_SIPO_PARITY_EN undefined: the PAR state and parity logic SHALL be absent, and parity_err SHALL be tied to 0.

Verification
REQ-029 WIDTH=8, out_ready=1, start plus serial 0xA5 LSB-first -> out_valid pulses 1 clk after bit 7, out_data=0xA5, busy low after the frame.
REQ-030 out_ready=0, two back-to-back frames 0x3C then 0x81 -> out_data holds 0x3C, overrun=1; clr_err -> overrun=0.
REQ-031 Frame 0x11 with out_ready raised exactly in its completion cycle while 0x22 is pending -> 0x22 is consumed, 0x11 loads, overrun stays 0.
REQ-032 start re-asserted at bit 4 of a frame, followed by 8 bits of 0xF0 -> single output 0xF0, no error.
REQ-033 rst pulsed at bit 3, then a full frame 0x5A -> all outputs 0 during reset, then out_data=0x5A.
REQ-034 DRAM_SIPO_PARITY_EN defined, 0x07 with parity bit 0 -> parity_err=1, out_data=0x07; with parity bit 1 -> parity_err stays 0.
